// File: rtl/word_serializer.sv
// word_serializer: parallel words in through a small FIFO,
// one bit per beat out, LSB first, with a last-bit marker.
module word_serializer #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             in_ready_q, in_ready_d;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;

  logic             fifo_empty;
  logic             fifo_full;
  logic             empty_d;
  logic             full_d;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = in_valid && !fifo_full;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  // Next state: shifter FSM, FIFO pointers and the registered outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    pop      = 1'b0;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = head;
          idx_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (out_ready) begin
          if (idx_q != LAST_IDX) begin
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + IW'(1);
          end else if (!fifo_empty) begin
            // Reload on the last beat so words run back to back.
            pop     = 1'b1;
            shreg_d = head;
            idx_d   = '0;
          end else begin
            idx_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = in_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    rd_ptr_d = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
              (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

    // Outputs are computed one edge ahead so they come straight off flops.
    in_ready_d  = !full_d;
    out_valid_d = (state_d == S_SHIFT);
    out_bit_d   = (state_d == S_SHIFT) && shreg_d[0];
    out_last_d  = (state_d == S_SHIFT) && (idx_d == LAST_IDX);
    busy_d      = !empty_d || (state_d == S_SHIFT);
  end

  // State and output registers; reset drops any buffered or partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      shreg_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      in_ready_q  <= 1'b1;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
      in_ready_q  <= in_ready_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: scoreboard bench for word_serializer,
// one WIDTH=2 instance and one WIDTH=3 instance.
`timescale 1ns/1ps
module tb_word_serializer;

  logic clk = 1'b0;
  logic reset;

  logic [1:0] in_data;
  logic       in_valid, in_ready;
  logic       out_bit, out_valid, out_last, out_ready, busy;

  logic [2:0] in3_data;
  logic       in3_valid, in3_ready;
  logic       out3_bit, out3_valid, out3_last, out3_ready, busy3;

  int n_tests = 0;
  int n_fail  = 0;

  // entries are {expected bit, expected last}
  logic [1:0] q2[$];
  logic [1:0] q3[$];
  logic [1:0] e2, e3;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(2), .DEPTH(2)) u2 (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_bit(out_bit), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  word_serializer #(.WIDTH(3), .DEPTH(2)) u3 (
    .clk(clk), .reset(reset),
    .in_data(in3_data), .in_valid(in3_valid), .in_ready(in3_ready),
    .out_bit(out3_bit), .out_valid(out3_valid), .out_last(out3_last),
    .out_ready(out3_ready), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Handshakes are sampled mid-cycle; inputs only move just after posedge.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready)
        for (int i = 0; i < 2; i++) q2.push_back({in_data[i], i == 1});
      if (out_valid && out_ready) begin
        if (q2.size() == 0) chk("w2_underflow", 1, 0);
        else begin
          e2 = q2.pop_front();
          chk("w2_bit", {31'd0, out_bit}, {31'd0, e2[1]});
          chk("w2_last", {31'd0, out_last}, {31'd0, e2[0]});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (in3_valid && in3_ready)
        for (int i = 0; i < 3; i++) q3.push_back({in3_data[i], i == 2});
      if (out3_valid && out3_ready) begin
        if (q3.size() == 0) chk("w3_underflow", 1, 0);
        else begin
          e3 = q3.pop_front();
          chk("w3_bit", {31'd0, out3_bit}, {31'd0, e3[1]});
          chk("w3_last", {31'd0, out3_last}, {31'd0, e3[0]});
        end
      end
    end
  end

  task automatic drain2(input string tag);
    int k;
    k = 0;
    while (busy && k < 40) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, busy}, 0);
    chk({tag, "_sb"}, q2.size(), 0);
  endtask

  task automatic drain3(input string tag);
    int k;
    k = 0;
    while (busy3 && k < 40) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, busy3}, 0);
    chk({tag, "_sb"}, q3.size(), 0);
  endtask

  logic [7:0] vseq, lseq;
  logic [1:0] bp_w [4];
  int         acc_n;
  logic       acc;

  initial begin
    reset = 1'b1;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    in3_data = '0; in3_valid = 1'b0; out3_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, in_ready}, 1);
    chk("rst_last", {31'd0, out_last}, 0);
    chk("rst_bit", {31'd0, out_bit}, 0);

    // single word 2'b10
    in_data = 2'b10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sw_lat_e1", {31'd0, out_valid}, 0);
    chk("sw_busy_e1", {31'd0, busy}, 1);
    tick();
    chk("sw_valid0", {31'd0, out_valid}, 1);
    chk("sw_bit0", {31'd0, out_bit}, 0);
    chk("sw_last0", {31'd0, out_last}, 0);
    tick();
    chk("sw_valid1", {31'd0, out_valid}, 1);
    chk("sw_bit1", {31'd0, out_bit}, 1);
    chk("sw_last1", {31'd0, out_last}, 1);
    tick();
    chk("sw_valid_end", {31'd0, out_valid}, 0);
    chk("sw_busy_end", {31'd0, busy}, 0);
    drain2("sw_drain");

    // back-to-back 01, 11, 00
    vseq = '0; lseq = '0;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 3);
      in_data  = (i == 0) ? 2'b01 : (i == 1) ? 2'b11 : 2'b00;
      tick();
      vseq[i] = out_valid;
      lseq[i] = out_last;
    end
    in_valid = 1'b0;
    chk("b2b_valid", {24'd0, vseq}, 32'h7e);
    chk("b2b_last", {24'd0, lseq}, 32'h54);
    drain2("b2b_drain");

    // backpressure: offer 4 words with the sink stalled
    bp_w[0] = 2'b01; bp_w[1] = 2'b10; bp_w[2] = 2'b11; bp_w[3] = 2'b00;
    out_ready = 1'b0;
    acc_n = 0;
    for (int c = 0; c < 8; c++) begin
      in_data  = bp_w[acc_n];
      in_valid = 1'b1;
      acc = in_ready;
      tick();
      if (acc) acc_n++;
      if (c >= 2) begin
        chk("bp_hold_bit", {31'd0, out_bit}, 1);
        chk("bp_hold_last", {31'd0, out_last}, 0);
        chk("bp_hold_valid", {31'd0, out_valid}, 1);
      end
    end
    chk("bp_accepted", acc_n, 3);
    chk("bp_in_ready", {31'd0, in_ready}, 0);
    chk("bp_busy", {31'd0, busy}, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && acc_n < 4; c++) begin
      acc = in_ready;
      tick();
      if (acc) acc_n++;
    end
    in_valid = 1'b0;
    chk("bp_fourth", acc_n, 4);
    drain2("bp_drain");

    // reset in the middle of 2'b10
    in_data = 2'b10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("rmw_pre_bit", {31'd0, out_bit}, 1);
    #1;
    reset = 1'b1;
    q2.delete();
    q3.delete();
    #1;
    chk("rmw_valid", {31'd0, out_valid}, 0);
    chk("rmw_last", {31'd0, out_last}, 0);
    chk("rmw_bit", {31'd0, out_bit}, 0);
    chk("rmw_busy", {31'd0, busy}, 0);
    chk("rmw_ready", {31'd0, in_ready}, 1);
    tick();
    reset = 1'b0;
    tick();
    chk("rmw_post_valid", {31'd0, out_valid}, 0);
    chk("rmw_post_busy", {31'd0, busy}, 0);
    in_data = 2'b11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rmw_new_bit0", {31'd0, out_bit}, 1);
    chk("rmw_new_last0", {31'd0, out_last}, 0);
    tick();
    chk("rmw_new_bit1", {31'd0, out_bit}, 1);
    chk("rmw_new_last1", {31'd0, out_last}, 1);
    drain2("rmw_drain");

    // WIDTH=3: 3'b110 then 3'b001 to see idx restart
    in3_data = 3'b110; in3_valid = 1'b1;
    tick();
    in3_valid = 1'b0;
    tick();
    chk("w3_b0", {31'd0, out3_bit}, 0);
    chk("w3_l0", {31'd0, out3_last}, 0);
    tick();
    chk("w3_b1", {31'd0, out3_bit}, 1);
    chk("w3_l1", {31'd0, out3_last}, 0);
    tick();
    chk("w3_b2", {31'd0, out3_bit}, 1);
    chk("w3_l2", {31'd0, out3_last}, 1);
    tick();
    chk("w3_idle", {31'd0, out3_valid}, 0);
    in3_data = 3'b001; in3_valid = 1'b1;
    tick();
    in3_valid = 1'b0;
    tick();
    chk("w3_wrap_b0", {31'd0, out3_bit}, 1);
    chk("w3_wrap_l0", {31'd0, out3_last}, 0);
    drain3("w3_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
